uart_wide_tx: RTL

Serialises one wide data word into a sequence of standard 8N1 UART bytes on `uart_txd`. It is the transmit counterpart of the wide-word UART receiver: the receiver assembles bytes into a `DATA_W`-bit word with a valid strobe, and this block takes such a word and emits it byte by byte. It sits between a word-level producer (accelerator result path or loopback test harness) and the board UART pin, using a valid/ready handshake on the word side.

---
 rtl/uart_wide_tx.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_wide_tx.sv
// uart_wide_tx
//   Sends one DATA_W-bit word as a back-to-back run of 8N1 UART frames.
//   The most significant byte is sent first. Bits within each byte go LSB first.
//   A word is accepted on a sys_clk edge where din_vld && din_rdy. The start bit
//   of the first byte begins on that same edge. There is no gap between bytes.
//
// Parameters
//   CLK_FREQ  sys_clk frequency in Hz
//   UART_BPS  baud rate; one bit lasts CLK_FREQ/UART_BPS cycles
//   DATA_W    word width, a multiple of 8
//
// Ports
//   sys_clk    clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   din        word to transmit, sampled only on accept
//   din_vld    producer has a word on din
//   din_rdy    block can accept a word (registered)
//   uart_txd   serial line, idle high (registered)
//   busy       a frame sequence is in progress (registered)
//
// Build option
//   UART_WIDE_TX_PARITY_EN  when defined, an even parity bit is inserted
//                           between the data bits and the stop bit (8E1).
//
// State | meaning
//   IDLE   | line high, waiting for din_vld && din_rdy
//   START  | start bit (0) of the current byte
//   DATA   | data bits 0..7 of the current byte, LSB first
//   PARITY | even parity of the current byte (parity build only)
//   STOP   | stop bit (1), then next byte or back to IDLE
module uart_wide_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200,
    parameter int DATA_W   = 256
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic              din_rdy,
    output logic              uart_txd,
    output logic              busy
);
    localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
    localparam int NBYTES   = DATA_W / 8;
    localparam int CNT_W    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam int BYTE_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_WIDE_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  baud_q,  baud_d;
    logic [2:0]        bit_q,   bit_d;
    logic [BYTE_W-1:0] byte_q,  byte_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              txd_q,   txd_d;
    logic              rdy_q,   rdy_d;
    logic              busy_q,  busy_d;

    logic [7:0] cur_byte;
    logic [2:0] bit_nxt;
    logic       baud_wrap;

    // The byte on the wire is always the top byte; the register shifts left
    // by one byte at the end of each stop bit.
    assign cur_byte  = shift_q[DATA_W-1 -: 8];
    assign bit_nxt   = bit_q + 3'd1;
    assign baud_wrap = (baud_q == CNT_W'(BAUD_CNT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;

        if (state_q != S_IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                rdy_d  = 1'b1;
                // rdy_q gates acceptance, so the first edge after reset only raises din_rdy.
                if (din_vld && rdy_q) begin
                    state_d = S_START;
                    shift_d = din;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    byte_d  = '0;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                    rdy_d   = 1'b0;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    txd_d   = cur_byte[0];
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_WIDE_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = ^cur_byte;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d = bit_nxt;
                        txd_d = cur_byte[bit_nxt];
                    end
                end
            end
`ifdef UART_WIDE_TX_PARITY_EN
            S_PARITY: begin
                if (baud_wrap) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_wrap) begin
                    if (byte_q == BYTE_W'(NBYTES - 1)) begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                        busy_d  = 1'b0;
                        rdy_d   = 1'b1;
                    end else begin
                        state_d = S_START;
                        byte_d  = byte_q + BYTE_W'(1);
                        shift_d = shift_q << 8;
                        txd_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                rdy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    assign uart_txd = txd_q;
    assign din_rdy  = rdy_q;
    assign busy     = busy_q;

endmodule
